snake_motion_ctrl: RTL



---
 rtl/snake_motion_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/snake_motion_ctrl.sv
// rtl/snake_motion_ctrl.sv - snake game sequencer: move pacing, direction, hits, growth, lose/win
module snake_motion_ctrl #(
    parameter int MAX_LEN     = 23,
    parameter int BLK         = 32,
    parameter int TICK_CYCLES = 8_000_000,
    parameter int START_X     = 400,
    parameter int START_Y     = 464,
    parameter int START_LEN   = 3,
    parameter int WIN_LEN     = 22,
    parameter int PX_MIN      = 16,
    parameter int PX_MAX      = 1392,
    parameter int PY_MIN      = 144,
    parameter int PY_MAX      = 848
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     btnrst_i,
    input  logic [3:0]               btn_dir_i,
    input  logic [10:0]              applepos_x_i,
    input  logic [10:0]              applepos_y_i,
    output logic [11*MAX_LEN-1:0]    snakepos_x_o,
    output logic [11*MAX_LEN-1:0]    snakepos_y_o,
    output logic [5:0]               length_o,
    output logic                     apple_eaten_o,
    output logic                     move_tick_o,
    output logic                     lose_o,
    output logic                     win_o
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_CYCLES - 1);
    localparam logic signed [11:0] BLK_S = 12'(BLK);
    localparam logic signed [11:0] X_MIN = 12'(PX_MIN);
    localparam logic signed [11:0] X_MAX = 12'(PX_MAX);
    localparam logic signed [11:0] Y_MIN = 12'(PY_MIN);
    localparam logic signed [11:0] Y_MAX = 12'(PY_MAX);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_LOSE, ST_WIN} state_e;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;

    // Slots past the live length start as copies of the last live segment
    function automatic logic [10:0] init_x(input int i);
        int k;
        k = (i < START_LEN) ? i : START_LEN - 1;
        return 11'(START_X - k * BLK);
    endfunction

    function automatic dir_e opposite(input dir_e d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

    state_e          state_q;
    dir_e            dir_q;
    dir_e            pend_q;
    logic [CW-1:0]   cnt_q;
    logic [5:0]      len_q;
    logic [10:0]     seg_x_q [MAX_LEN];
    logic [10:0]     seg_y_q [MAX_LEN];
    logic            move_tick_q;
    logic            apple_eaten_q;
    logic            lose_q;
    logic            win_q;

    logic            press_vld;
    dir_e            press_dir;
    logic            step;
    dir_e            dir_after;
    logic            accept;
    logic signed [11:0] hx, hy, dx, dy, nx, ny;
    logic            wall;
    logic            grow;
    logic            self_hit;

    // Button decode and reverse filter against the direction in force after this cycle
    always_comb begin
        press_vld = |btn_dir_i;
        press_dir = DIR_RIGHT;
        if (btn_dir_i[3])      press_dir = DIR_UP;
        else if (btn_dir_i[2]) press_dir = DIR_DOWN;
        else if (btn_dir_i[1]) press_dir = DIR_LEFT;
        step      = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
        dir_after = step ? pend_q : dir_q;
        accept    = press_vld && (press_dir != opposite(dir_after));
    end

    // Candidate head position and the wall / apple / body tests for the next step
    always_comb begin
        hx = $signed({1'b0, seg_x_q[0]});
        hy = $signed({1'b0, seg_y_q[0]});
        dx = '0;
        dy = '0;
        case (pend_q)
            DIR_UP:    dy = -BLK_S;
            DIR_DOWN:  dy = BLK_S;
            DIR_LEFT:  dx = -BLK_S;
            default:   dx = BLK_S;
        endcase
        nx   = hx + dx;
        ny   = hy + dy;
        wall = (nx < X_MIN) || (nx > X_MAX) || (ny < Y_MIN) || (ny > Y_MAX);
        grow = (nx == $signed({1'b0, applepos_x_i})) && (ny == $signed({1'b0, applepos_y_i}));
        self_hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if (((i < int'(len_q) - 1) || (grow && (i == int'(len_q) - 1))) &&
                ($signed({1'b0, seg_x_q[i]}) == nx) &&
                ($signed({1'b0, seg_y_q[i]}) == ny)) begin
                self_hit = 1'b1;
            end
        end
    end

    // Game state machine owning the body registers and all registered outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= ST_IDLE;
            dir_q         <= DIR_RIGHT;
            pend_q        <= DIR_RIGHT;
            cnt_q         <= '0;
            len_q         <= 6'(START_LEN);
            move_tick_q   <= 1'b0;
            apple_eaten_q <= 1'b0;
            lose_q        <= 1'b0;
            win_q         <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= 11'(START_Y);
            end
        end else if (btnrst_i) begin
            state_q       <= ST_IDLE;
            dir_q         <= DIR_RIGHT;
            pend_q        <= DIR_RIGHT;
            cnt_q         <= '0;
            len_q         <= 6'(START_LEN);
            move_tick_q   <= 1'b0;
            apple_eaten_q <= 1'b0;
            lose_q        <= 1'b0;
            win_q         <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= 11'(START_Y);
            end
        end else begin
            move_tick_q   <= 1'b0;
            apple_eaten_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (press_vld) begin
                        state_q <= ST_RUN;
                        if (accept) pend_q <= press_dir;
                    end
                end
                ST_RUN: begin
                    if (accept) pend_q <= press_dir;
                    if (step) begin
                        cnt_q <= '0;
                        dir_q <= pend_q;
                        if (wall || self_hit) begin
                            state_q <= ST_LOSE;
                            lose_q  <= 1'b1;
                        end else begin
                            for (int i = 1; i < MAX_LEN; i++) begin
                                seg_x_q[i] <= seg_x_q[i-1];
                                seg_y_q[i] <= seg_y_q[i-1];
                            end
                            seg_x_q[0]  <= nx[10:0];
                            seg_y_q[0]  <= ny[10:0];
                            move_tick_q <= 1'b1;
                            if (grow) begin
                                len_q         <= len_q + 6'd1;
                                apple_eaten_q <= 1'b1;
                                if (len_q + 6'd1 == 6'(WIN_LEN)) begin
                                    state_q <= ST_WIN;
                                    win_q   <= 1'b1;
                                end
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Flatten the segment registers onto the drawcon buses
    always_comb begin
        snakepos_x_o = '0;
        snakepos_y_o = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            snakepos_x_o[11*i +: 11] = seg_x_q[i];
            snakepos_y_o[11*i +: 11] = seg_y_q[i];
        end
    end

    assign length_o      = len_q;
    assign apple_eaten_o = apple_eaten_q;
    assign move_tick_o   = move_tick_q;
    assign lose_o        = lose_q;
    assign win_o         = win_q;

endmodule
